// File: rtl/ko_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ko_sequencer
// Purpose  : Round-end controller. When a fighter's health reaches zero it
//            blinks the KO banner, then holds it solid, freezes fighter
//            motion, and raises round_over until the game FSM starts a new
//            round. All timing is counted in frames, using rising edges of
//            frame_clk as seen in the Clk domain.
// Ports    : Clk          - system clock
//            Reset        - asynchronous, active-high reset
//            frame_clk    - frame-rate clock, sampled in the Clk domain
//            p1_hp_zero   - level, player 1 health is zero
//            p2_hp_zero   - level, player 2 health is zero
//            start_round  - one-cycle pulse, request a new round
//            exist_ko     - enable to the KO sprite drawing block
//            freeze       - freeze fighter motion and input
//            round_over   - level, round finished (held until start_round)
//            winner       - 00 none, 01 P1, 10 P2, 11 draw
//            state_dbg    - IDLE=0, FLASH=1, HOLD=2, DONE=3
// Revision : 1.0 - initial release
// ============================================================================
module ko_sequencer #(
  parameter int FLASH_FRAMES = 64,
  parameter int FLASH_PERIOD = 8,
  parameter int HOLD_FRAMES  = 120,
  parameter int CNT_W        = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       p1_hp_zero,
  input  logic       p2_hp_zero,
  input  logic       start_round,
  output logic       exist_ko,
  output logic       freeze,
  output logic       round_over,
  output logic [1:0] winner,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLASH = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counter bit whose value selects the on/off half of each blink period.
  localparam int             c_blink_bit  = $clog2(FLASH_PERIOD);
  localparam logic [CNT_W-1:0] c_flash_last = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_hold_last  = CNT_W'(HOLD_FRAMES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               exist_ko_q, exist_ko_d;
  logic               freeze_q, freeze_d;
  logic               round_over_q, round_over_d;
  logic [1:0]         winner_q, winner_d;
  logic               frame_clk_q;

  logic               w_tick;
  logic [CNT_W-1:0]   w_cnt_inc;

  // One-Clk pulse per rising edge of frame_clk; a frame_clk held high
  // produces exactly one tick.
  assign w_tick    = frame_clk & ~frame_clk_q;
  assign w_cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      exist_ko_q   <= 1'b0;
      freeze_q     <= 1'b0;
      round_over_q <= 1'b0;
      winner_q     <= 2'b00;
      frame_clk_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      exist_ko_q   <= exist_ko_d;
      freeze_q     <= freeze_d;
      round_over_q <= round_over_d;
      winner_q     <= winner_d;
      frame_clk_q  <= frame_clk;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    exist_ko_d   = exist_ko_q;
    freeze_d     = freeze_q;
    round_over_d = round_over_q;
    winner_d     = winner_q;

    case (state_q)
      S_IDLE: begin
        if (p1_hp_zero || p2_hp_zero) begin
          state_d    = S_FLASH;
          cnt_d      = '0;
          exist_ko_d = 1'b1;
          freeze_d   = 1'b1;
          // A fighter at zero health loses: {p1,p2} gives 01 when only P2
          // is down (P1 wins), 10 when only P1 is down, 11 for a draw.
          winner_d   = {p1_hp_zero, p2_hp_zero};
        end
      end

      S_FLASH: begin
        if (w_tick) begin
          if (cnt_q == c_flash_last) begin
            state_d    = S_HOLD;
            cnt_d      = '0;
            exist_ko_d = 1'b1;
          end else begin
            cnt_d      = w_cnt_inc;
            // Banner shows while the blink bit of the new frame count is 0.
            exist_ko_d = ~w_cnt_inc[c_blink_bit];
          end
        end
      end

      S_HOLD: begin
        exist_ko_d = 1'b1;
        freeze_d   = 1'b1;
        if (w_tick) begin
          if (cnt_q == c_hold_last) begin
            state_d      = S_DONE;
            round_over_d = 1'b1;
          end else begin
            cnt_d = w_cnt_inc;
          end
        end
      end

      S_DONE: begin
        exist_ko_d   = 1'b1;
        freeze_d     = 1'b1;
        round_over_d = 1'b1;
        // start_round takes priority over any tick arriving with it.
        if (start_round) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          exist_ko_d   = 1'b0;
          freeze_d     = 1'b0;
          round_over_d = 1'b0;
          winner_d     = 2'b00;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign exist_ko   = exist_ko_q;
  assign freeze     = freeze_q;
  assign round_over = round_over_q;
  assign winner     = winner_q;
  assign state_dbg  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ko_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ko_sequencer
// Purpose  : Self-checking bench for ko_sequencer. Expected output vectors
//            {state_dbg, winner, round_over, freeze, exist_ko} are queued
//            when a stimulus step is driven and compared once the DUT has
//            clocked that step.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ko_sequencer;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       p1_hp_zero;
  logic       p2_hp_zero;
  logic       start_round;
  logic       exist_ko;
  logic       freeze;
  logic       round_over;
  logic [1:0] winner;
  logic [1:0] state_dbg;

  ko_sequencer #(
    .FLASH_FRAMES (64),
    .FLASH_PERIOD (8),
    .HOLD_FRAMES  (120),
    .CNT_W        (8)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .p1_hp_zero  (p1_hp_zero),
    .p2_hp_zero  (p2_hp_zero),
    .start_round (start_round),
    .exist_ko    (exist_ko),
    .freeze      (freeze),
    .round_over  (round_over),
    .winner      (winner),
    .state_dbg   (state_dbg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st,
                            input logic [1:0] w, input logic ro,
                            input logic fr, input logic ex);
    exp_t e;
    e.tag = tag;
    e.exp = {st, w, ro, fr, ex};
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t       e;
    logic [6:0] obs;
    obs = {state_dbg, winner, round_over, freeze, exist_ko};
    vectors++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One full frame: a rising edge of frame_clk seen on one Clk edge, then low.
  task automatic frame_tick();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  initial begin
    Reset       = 1'b1;
    frame_clk   = 1'b0;
    p1_hp_zero  = 1'b0;
    p2_hp_zero  = 1'b0;
    start_round = 1'b0;

    // Reset state
    expect_out("reset_state", 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    compare_out();
    Reset = 1'b0;

    // start_round in IDLE is ignored
    expect_out("idle_start_ignored", 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    start_round = 1'b1;
    step();
    start_round = 1'b0;
    step();
    compare_out();

    // P2 health hits zero for one cycle -> FLASH, P1 wins, 1 Clk latency
    expect_out("p2_ko_entry", 2'd1, 2'b01, 1'b0, 1'b1, 1'b1);
    p2_hp_zero = 1'b1;
    step();
    p2_hp_zero = 1'b0;
    compare_out();

    // Blink: 8 frames on, 8 off, over 63 ticks
    for (int i = 1; i < 64; i++) begin
      expect_out($sformatf("flash_tick_%0d", i), 2'd1, 2'b01, 1'b0, 1'b1,
                 ((i / 8) % 2) == 0);
      frame_tick();
      compare_out();
    end
    expect_out("flash_to_hold", 2'd2, 2'b01, 1'b0, 1'b1, 1'b1);
    frame_tick();
    compare_out();

    // HOLD for 120 ticks
    for (int i = 1; i < 120; i++) begin
      expect_out($sformatf("hold_tick_%0d", i), 2'd2, 2'b01, 1'b0, 1'b1, 1'b1);
      frame_tick();
      compare_out();
    end
    expect_out("hold_to_done", 2'd3, 2'b01, 1'b1, 1'b1, 1'b1);
    frame_tick();
    compare_out();

    // DONE ignores hp_zero and further ticks
    expect_out("done_hp_ignored", 2'd3, 2'b01, 1'b1, 1'b1, 1'b1);
    p1_hp_zero = 1'b1;
    step();
    p1_hp_zero = 1'b0;
    frame_tick();
    compare_out();

    // start_round together with a tick in DONE: start_round wins
    expect_out("done_start_round", 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    start_round = 1'b1;
    frame_clk   = 1'b1;
    step();
    start_round = 1'b0;
    frame_clk   = 1'b0;
    compare_out();
    expect_out("idle_after_restart", 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    compare_out();

    // Both fighters at zero in the same cycle -> draw
    expect_out("draw_entry", 2'd1, 2'b11, 1'b0, 1'b1, 1'b1);
    p1_hp_zero = 1'b1;
    p2_hp_zero = 1'b1;
    step();
    p1_hp_zero = 1'b0;
    p2_hp_zero = 1'b0;
    compare_out();

    for (int i = 1; i <= 5; i++) begin
      expect_out($sformatf("draw_flash_tick_%0d", i), 2'd1, 2'b11, 1'b0, 1'b1, 1'b1);
      frame_tick();
      compare_out();
    end

    // Later p1_hp_zero toggle in FLASH does not re-latch winner
    expect_out("flash_hp_ignored", 2'd1, 2'b11, 1'b0, 1'b1, 1'b1);
    p1_hp_zero = 1'b1;
    step();
    p1_hp_zero = 1'b0;
    step();
    compare_out();

    // start_round in FLASH is ignored
    expect_out("flash_start_ignored", 2'd1, 2'b11, 1'b0, 1'b1, 1'b1);
    start_round = 1'b1;
    step();
    start_round = 1'b0;
    step();
    compare_out();

    // frame_clk held high for 1000 Clk gives exactly one tick (count 5 -> 6)
    expect_out("held_frame_clk", 2'd1, 2'b11, 1'b0, 1'b1, 1'b1);
    frame_clk = 1'b1;
    repeat (1000) step();
    frame_clk = 1'b0;
    step();
    compare_out();

    // Count now 6: 57 more ticks stay in FLASH, the 58th enters HOLD
    for (int i = 7; i < 64; i++) begin
      expect_out($sformatf("draw_flash_tick_%0d", i), 2'd1, 2'b11, 1'b0, 1'b1,
                 ((i / 8) % 2) == 0);
      frame_tick();
      compare_out();
    end
    expect_out("draw_flash_to_hold", 2'd2, 2'b11, 1'b0, 1'b1, 1'b1);
    frame_tick();
    compare_out();

    // Advance HOLD to count 50, then reset asynchronously mid-cycle
    for (int i = 1; i <= 50; i++) frame_tick();
    expect_out("draw_hold_50", 2'd2, 2'b11, 1'b0, 1'b1, 1'b1);
    compare_out();

    expect_out("async_reset_hold", 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    compare_out();
    @(negedge Clk);
    Reset = 1'b0;
    expect_out("idle_after_reset", 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    compare_out();

    if (sb_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
